// File: rtl/serial_out_feeder.sv
// serial_out_feeder: byte FIFO that paces parallel loads into a downstream shift register.
module serial_out_feeder #(
  parameter int DEPTH = 4,
  parameter int SHIFT_CYCLES = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [7:0]               data_in,
  input  logic                     valid_in,
  output logic                     ready_out,
  output logic [7:0]               vect_out,
  output logic                     start_out,
  output logic                     busy_out,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SHIFT_CYCLES);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [CW-1:0] WLAST = CW'(SHIFT_CYCLES - 2);
  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;
  state_t state;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] wcnt;
  logic push, load;
  assign ready_out = count_out < FULL;
  assign push = valid_in && ready_out;
  // occupancy is sampled from the register, so a byte landing in the last WAIT cycle waits for IDLE
  assign load = count_out != '0 && (state == IDLE || (state == WAIT && wcnt == WLAST));
  assign busy_out = state != IDLE || count_out != '0;
  always_ff @(posedge clk_in)
    if (!rst_in && push) mem[wp] <= data_in;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      wcnt <= '0;
      count_out <= '0;
      vect_out <= '0;
      start_out <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (load) begin
        vect_out <= mem[rp];
        rp <= rp + 1'b1;
      end
      count_out <= count_out + (AW+1)'(push) - (AW+1)'(load);
      start_out <= load;
      wcnt <= state == WAIT ? wcnt + 1'b1 : '0;
      state <= load ? SEND :
               state == SEND ? WAIT :
               (state == WAIT && wcnt == WLAST) ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_serial_out_feeder.sv
// tb_serial_out_feeder: directed steps with a byte scoreboard checked on every start pulse.
module tb_serial_out_feeder;
  localparam int SHIFT = 8;
  logic clk = 0, rst = 1, valid = 0;
  logic [7:0] data = '0;
  logic ready, start, busy;
  logic [7:0] vect;
  logic [2:0] count;
  int checks = 0, errors = 0, cyc = 0, last = 0, npulse = 0, npush = 0;
  bit have_last = 0;
  logic [7:0] sb[$];
  int gaps[$];

  serial_out_feeder #(.DEPTH(4), .SHIFT_CYCLES(SHIFT)) dut (
    .clk_in(clk), .rst_in(rst), .data_in(data), .valid_in(valid),
    .ready_out(ready), .vect_out(vect), .start_out(start),
    .busy_out(busy), .count_out(count));

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    cyc++;
    if (start) begin
      checks++;
      assert (sb.size() > 0 && vect === sb[0]) else begin
        errors++;
        $error("FAIL sb_vect observed=%0h expected=%0h", vect, sb.size() > 0 ? sb[0] : 8'h00);
      end
      if (sb.size() > 0) void'(sb.pop_front());
      if (have_last) begin
        gaps.push_back(cyc - last);
        checks++;
        assert (cyc - last >= SHIFT) else begin
          errors++;
          $error("FAIL pulse_gap observed=%0d expected>=%0d", cyc - last, SHIFT);
        end
      end
      have_last = 1;
      last = cyc;
      npulse++;
    end
    if (rst) begin
      sb.delete();
      have_last = 0;
    end else if (valid && ready) begin
      sb.push_back(data);
      npush++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst = 1;
    valid = 0;
    tick;
    rst = 0;
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && (busy || sb.size() > 0); i++) tick;
    chk("drain_busy", busy, 0);
    chk("drain_sb_empty", sb.size(), 0);
  endtask

  initial begin
    int np0, nq0, peak;
    bit saw_low;
    logic [7:0] burst [4];
    burst = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    repeat (2) tick;
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_ready", ready, 1);
    chk("rst_vect", vect, 8'h00);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);

    // single byte: pulse two edges after acceptance, busy clears SHIFT cycles after pulse
    data = 8'h01; valid = 1; tick; valid = 0;
    chk("single_start_early", start, 0);
    chk("single_count", count, 1);
    tick;
    chk("single_start", start, 1);
    chk("single_vect", vect, 8'h01);
    for (int i = 1; i <= 7; i++) begin
      tick;
      if (i == 1) chk("single_pulse_width", start, 0);
    end
    chk("single_busy_wait", busy, 1);
    tick;
    chk("single_busy_clear", busy, 0);
    chk("single_vect_hold", vect, 8'h01);

    // burst of four
    do_reset; gaps.delete(); np0 = npulse; peak = 0;
    for (int i = 0; i < 4; i++) begin
      data = burst[i]; valid = 1; tick;
      if (int'(count) > peak) peak = count;
    end
    valid = 0;
    drain;
    chk("burst_pulses", npulse - np0, 4);
    chk("burst_peak_ok", peak >= 3 && peak <= 4, 1);
    chk("burst_ngaps", gaps.size(), 3);
    foreach (gaps[i]) chk("burst_gap", gaps[i], SHIFT);

    // overflow: 0x10..0x17 held valid, only five fit
    do_reset; np0 = npulse; nq0 = npush; saw_low = 0;
    for (int i = 0; i < 8; i++) begin
      data = 8'h10 + 8'(i); valid = 1; tick;
      if (!ready) saw_low = 1;
    end
    valid = 0;
    chk("ovf_ready_dropped", saw_low, 1);
    chk("ovf_count_full", count, 4);
    chk("ovf_accepted", npush - nq0, 5);
    drain;
    chk("ovf_pulses", npulse - np0, 5);

    // push on the same edge as a pop
    do_reset;
    data = 8'h61; valid = 1; tick;
    chk("sim_count_1", count, 1);
    data = 8'h62; tick; valid = 0;
    chk("sim_count_same", count, 1);
    chk("sim_start", start, 1);
    chk("sim_vect", vect, 8'h61);
    drain;

    // reset in the middle of a WAIT with two bytes queued, plus a transfer attempt during reset
    do_reset;
    data = 8'h31; valid = 1; tick;
    data = 8'h32; tick;
    chk("mid_start", start, 1);
    data = 8'h33; tick; valid = 0;
    chk("mid_queued", count, 2);
    repeat (2) tick;
    rst = 1; valid = 1; data = 8'h77; tick;
    rst = 0; valid = 0;
    chk("mid_count", count, 0);
    chk("mid_ready", ready, 1);
    chk("mid_vect", vect, 8'h00);
    chk("mid_start_low", start, 0);
    chk("mid_busy", busy, 0);
    np0 = npulse;
    repeat (20) tick;
    chk("mid_no_pulse", npulse - np0, 0);
    chk("mid_busy_after", busy, 0);

    // byte written in the last WAIT cycle goes through IDLE first
    do_reset; gaps.delete();
    data = 8'hAA; valid = 1; tick; valid = 0;
    tick;
    chk("bnd_start_aa", start, 1);
    chk("bnd_vect_aa", vect, 8'hAA);
    repeat (7) tick;
    chk("bnd_in_wait", busy, 1);
    data = 8'h55; valid = 1; tick; valid = 0;
    chk("bnd_no_b2b", start, 0);
    chk("bnd_count", count, 1);
    tick;
    chk("bnd_start_55", start, 1);
    chk("bnd_vect_55", vect, 8'h55);
    drain;
    chk("bnd_ngaps", gaps.size(), 1);
    if (gaps.size() > 0) chk("bnd_gap", gaps[0], SHIFT + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
